// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared constants and types for the 24-bit 5-stage core.
//   DATA_W   : datapath / register width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   ZERO_REG : index of the hardwired zero register
//   memwb_t  : MEM/WB write-back bundle, also consumed by hazard/forwarding logic
package cpu_pkg;

  localparam int DATA_W   = 24;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
  } memwb_t;

endpackage

// File: rtl/register_file.sv
// register_file
// Architectural register file: 2 combinational read ports, 1 write port.
// R0 reads as zero and ignores writes. Synchronous active-high reset clears
// every register.
//   clk      : core clock, rising edge
//   reset    : synchronous active-high reset
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr1_i : read address 1  -> rdata1_o
//   raddr2_i : read address 2  -> rdata2_o
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wrEn;

  // Writes to the zero register are dropped so it can never hold a value.
  assign wrEn = we_i && (int'(waddr_i) != ZERO_REG);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrEn) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // No write-to-read bypass: a same-cycle write is seen only after the edge.
  assign rdata1_o = (int'(raddr1_i) == ZERO_REG) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (int'(raddr2_i) == ZERO_REG) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/wb_regfile_writer.sv
// wb_regfile_writer
// Write-back stage: MEM/WB pipeline register, write-back result mux, and the
// architectural register file with its two decode-stage read ports.
//   clk, reset        : core clock / synchronous active-high reset
//   stall, flush      : hold / bubble the MEM/WB register (flush wins)
//   RegWrite_in, MemToReg_in, WriteRegister_in, ALUResult_in, MemData_in
//                     : MEM-stage instruction results
//   rs, rt            : decode read addresses -> ReadData1, ReadData2
//   RegWrite, WriteRegister, WriteData
//                     : WB-stage write bus, also feeds forwarding logic
module wb_regfile_writer
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              RegWrite_in,
  input  logic              MemToReg_in,
  input  logic [ADDR_W-1:0] WriteRegister_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] MemData_in,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData
);

  logic              regWrite_q,  regWrite_d;
  logic [ADDR_W-1:0] writeReg_q,  writeReg_d;
  logic [DATA_W-1:0] writeData_q, writeData_d;

  // Next MEM/WB entry: flush inserts a bubble, stall holds, otherwise load
  // the incoming instruction with its selected result.
  always_comb begin
    regWrite_d  = regWrite_q;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    if (flush) begin
      regWrite_d  = 1'b0;
      writeReg_d  = '0;
      writeData_d = '0;
    end else if (!stall) begin
      regWrite_d  = RegWrite_in;
      writeReg_d  = WriteRegister_in;
      writeData_d = MemToReg_in ? MemData_in : ALUResult_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
    end
  end

  assign RegWrite      = regWrite_q;
  assign WriteRegister = writeReg_q;
  assign WriteData     = writeData_q;

  // The commit uses the registered WB bus, so the entry being displaced by a
  // flush (or held by a stall) is still written; reset clears the file first.
  register_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (regWrite_q),
    .waddr_i  (writeReg_q),
    .wdata_i  (writeData_q),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (ReadData1),
    .rdata2_o (ReadData2)
  );

endmodule

// File: tb/tb_wb_regfile_writer.sv
// tb_wb_regfile_writer
// Self-checking bench for wb_regfile_writer: directed scenarios plus a
// randomized run compared against a behavioural register-file model.
module tb_wb_regfile_writer;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        RegWrite_in, MemToReg_in;
  logic [3:0]  WriteRegister_in;
  logic [23:0] ALUResult_in, MemData_in;
  logic [3:0]  rs, rt;
  logic [23:0] ReadData1, ReadData2;
  logic        RegWrite;
  logic [3:0]  WriteRegister;
  logic [23:0] WriteData;

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural registers and the pending WB entry.
  logic [23:0] mRegs [16];
  logic        mWe;
  logic [3:0]  mWa;
  logic [23:0] mWd;

  wb_regfile_writer dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .RegWrite_in      (RegWrite_in),
    .MemToReg_in      (MemToReg_in),
    .WriteRegister_in (WriteRegister_in),
    .ALUResult_in     (ALUResult_in),
    .MemData_in       (MemData_in),
    .rs               (rs),
    .rt               (rt),
    .ReadData1        (ReadData1),
    .ReadData2        (ReadData2),
    .RegWrite         (RegWrite),
    .WriteRegister    (WriteRegister),
    .WriteData        (WriteData)
  );

  always #5 clk = ~clk;

  // One clock edge of the architectural behaviour.
  task automatic modelStep();
    if (reset) begin
      for (int i = 0; i < 16; i++) mRegs[i] = 24'h0;
      mWe = 1'b0; mWa = 4'h0; mWd = 24'h0;
    end else begin
      if (mWe && mWa != 4'h0) mRegs[mWa] = mWd;
      if (flush) begin
        mWe = 1'b0; mWa = 4'h0; mWd = 24'h0;
      end else if (!stall) begin
        mWe = RegWrite_in;
        mWa = WriteRegister_in;
        mWd = MemToReg_in ? MemData_in : ALUResult_in;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0;
    RegWrite_in = 0; MemToReg_in = 0; WriteRegister_in = 0;
    ALUResult_in = 0; MemData_in = 0;
  endtask

  task automatic load(input logic [3:0] dst, input logic m2r,
                      input logic [23:0] alu, input logic [23:0] mem);
    RegWrite_in = 1; MemToReg_in = m2r; WriteRegister_in = dst;
    ALUResult_in = alu; MemData_in = mem;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    checks++;
    if (RegWrite !== 1'b0 || WriteRegister !== 4'h0 || WriteData !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus got %b/%0d/%h want 0/0/000000", RegWrite, WriteRegister, WriteData);
    end
    for (int a = 0; a < 16; a++) begin
      rs = a[3:0]; rt = 4'(15 - a);
      #1;
      checks++;
      if (ReadData1 !== 24'h0 || ReadData2 !== 24'h0) begin
        errors++;
        $display("[TB] FAIL reset_read a=%0d got %h/%h want 000000", a, ReadData1, ReadData2);
      end
    end
  endtask

  task automatic test_alu_path();
    idle();
    load(4'd5, 1'b0, 24'h123456, 24'h987654);
    tick();
    idle();
    rs = 4'd5;
    #1;
    checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 4'd5 || WriteData !== 24'h123456) begin
      errors++;
      $display("[TB] FAIL alu_bus got %b/%0d/%h want 1/5/123456", RegWrite, WriteRegister, WriteData);
    end
    checks++;
    if (ReadData1 !== 24'h0) begin
      errors++;
      $display("[TB] FAIL alu_no_bypass got %h want 000000", ReadData1);
    end
    tick();
    checks++;
    if (ReadData1 !== 24'h123456) begin
      errors++;
      $display("[TB] FAIL alu_commit got %h want 123456", ReadData1);
    end
  endtask

  task automatic test_mem_path();
    idle();
    load(4'd3, 1'b1, 24'h111111, 24'hABCDEF);
    tick();
    idle();
    checks++;
    if (WriteData !== 24'hABCDEF || WriteRegister !== 4'd3) begin
      errors++;
      $display("[TB] FAIL mem_bus got %0d/%h want 3/abcdef", WriteRegister, WriteData);
    end
    tick();
    rt = 4'd3;
    #1;
    checks++;
    if (ReadData2 !== 24'hABCDEF) begin
      errors++;
      $display("[TB] FAIL mem_commit got %h want abcdef", ReadData2);
    end
  endtask

  task automatic test_r0();
    idle();
    load(4'd0, 1'b0, 24'hFFFFFF, 24'h0);
    tick();
    idle();
    rs = 4'd0; rt = 4'd0;
    #1;
    checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 4'd0 || WriteData !== 24'hFFFFFF) begin
      errors++;
      $display("[TB] FAIL r0_bus got %b/%0d/%h want 1/0/ffffff", RegWrite, WriteRegister, WriteData);
    end
    tick();
    tick();
    checks++;
    if (ReadData1 !== 24'h0 || ReadData2 !== 24'h0) begin
      errors++;
      $display("[TB] FAIL r0_read got %h/%h want 000000", ReadData1, ReadData2);
    end
  endtask

  task automatic test_stall();
    idle();
    load(4'd7, 1'b0, 24'h000042, 24'h0);
    tick();
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      load(4'd8, 1'($urandom), 24'($urandom), 24'($urandom));
      tick();
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== 4'd7 || WriteData !== 24'h000042) begin
        errors++;
        $display("[TB] FAIL stall_hold c=%0d got %b/%0d/%h want 1/7/000042", c, RegWrite, WriteRegister, WriteData);
      end
    end
    rs = 4'd7; rt = 4'd8;
    #1;
    checks++;
    if (ReadData1 !== 24'h000042 || ReadData2 !== 24'h0) begin
      errors++;
      $display("[TB] FAIL stall_regs got %h/%h want 000042/000000", ReadData1, ReadData2);
    end
    flush = 1;
    tick();
    checks++;
    if (RegWrite !== 1'b0 || WriteRegister !== 4'h0 || WriteData !== 24'h0) begin
      errors++;
      $display("[TB] FAIL stall_flush got %b/%0d/%h want 0/0/000000", RegWrite, WriteRegister, WriteData);
    end
    idle();
    tick();
    checks++;
    if (ReadData2 !== 24'h0 || ReadData1 !== 24'h000042) begin
      errors++;
      $display("[TB] FAIL stall_after got %h/%h want 000042/000000", ReadData1, ReadData2);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    load(4'd9, 1'b0, 24'h0000AA, 24'h0);
    tick();
    idle();
    reset = 1;
    tick();
    reset = 0;
    rs = 4'd9; rt = 4'd5;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || WriteRegister !== 4'h0 || WriteData !== 24'h0) begin
      errors++;
      $display("[TB] FAIL midreset_bus got %b/%0d/%h want 0/0/000000", RegWrite, WriteRegister, WriteData);
    end
    checks++;
    if (ReadData1 !== 24'h0 || ReadData2 !== 24'h0) begin
      errors++;
      $display("[TB] FAIL midreset_regs got %h/%h want 000000", ReadData1, ReadData2);
    end
  endtask

  task automatic test_flush();
    idle();
    load(4'd2, 1'b0, 24'h222222, 24'h0);
    flush = 1;
    tick();
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_bus got RegWrite=%b want 0", RegWrite);
    end
    idle();
    tick();
    tick();
    rs = 4'd2;
    #1;
    checks++;
    if (ReadData1 !== 24'h0) begin
      errors++;
      $display("[TB] FAIL flush_r2 got %h want 000000", ReadData1);
    end
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      reset            = ($urandom_range(0, 99) == 0);
      stall            = ($urandom_range(0, 7) == 0);
      flush            = ($urandom_range(0, 9) == 0);
      RegWrite_in      = 1'($urandom);
      MemToReg_in      = 1'($urandom);
      WriteRegister_in = 4'($urandom);
      ALUResult_in     = 24'($urandom);
      MemData_in       = 24'($urandom);
      tick();
      rs = 4'($urandom); rt = 4'($urandom);
      #1;
      checks++;
      if (RegWrite !== mWe || WriteRegister !== mWa || WriteData !== mWd) begin
        errors++;
        $display("[TB] FAIL rand_bus c=%0d got %b/%0d/%h want %b/%0d/%h", c, RegWrite, WriteRegister, WriteData, mWe, mWa, mWd);
      end
      checks++;
      if (ReadData1 !== mRegs[rs] || ReadData2 !== mRegs[rt]) begin
        errors++;
        $display("[TB] FAIL rand_read c=%0d rs=%0d rt=%0d got %h/%h want %h/%h", c, rs, rt, ReadData1, ReadData2, mRegs[rs], mRegs[rt]);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mRegs[i] = 24'h0;
    mWe = 0; mWa = 0; mWd = 0;
    rs = 0; rt = 0;
    idle();
    test_reset();
    test_alu_path();
    test_mem_path();
    test_r0();
    test_stall();
    test_reset_mid();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Write-back end of the register-file interface; the producer of the WriteRegister/WriteData/RegWrite bus that the decode-stage forwarding logic consumes.
- Holds the MEM/WB pipeline register and selects the write-back result (ALU result or memory load data).
- Commits results into the 16 x 24-bit architectural register file and serves the two raw decode-stage read ports (rs/rt).
- Sits between the MEM stage and the decode stage of the 5-stage 24-bit core.

Parameters:
DATA_W, 24, datapath / register width
ADDR_W, 4, register address width (2**ADDR_W registers)

Ports:
clk  input  1  core clock, rising-edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold the MEM/WB register contents
flush  input  1  replace the incoming MEM/WB entry with a bubble
RegWrite_in  input  1  MEM-stage instruction writes a register
MemToReg_in  input  1  1 = write-back value is MemData_in, 0 = ALUResult_in
WriteRegister_in  input  ADDR_W  MEM-stage destination register
ALUResult_in  input  DATA_W  MEM-stage ALU result
MemData_in  input  DATA_W  data-memory read data
rs  input  ADDR_W  decode read address 1
rt  input  ADDR_W  decode read address 2
ReadData1  output  DATA_W  raw register-file contents at rs
ReadData2  output  DATA_W  raw register-file contents at rt
RegWrite  output  1  WB-stage write enable (to forwarding logic)
WriteRegister  output  ADDR_W  WB-stage destination register
WriteData  output  DATA_W  WB-stage write value

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high, sampled on the rising edge of clk. Reset has priority over all other inputs.
- Reset values:
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - All registers R0..R15 = 0.
- MEM/WB register update, evaluated each rising edge in priority order reset > flush > stall > load:
  - flush: RegWrite<=0, WriteRegister<=0, WriteData<=0 (bubble).
  - stall (without flush): all three outputs hold their values.
  - load: RegWrite<=RegWrite_in, WriteRegister<=WriteRegister_in, WriteData<=(MemToReg_in ? MemData_in : ALUResult_in).
- Latency: a MEM-stage value is visible on the WB bus 1 cycle after capture. It is committed to the register file on the following edge, so it reaches ReadData 2 edges after capture.
- Register commit:
  - On each non-reset rising edge, if RegWrite==1 and WriteRegister!=0, then regs[WriteRegister] <= WriteData. This uses the current WB bus values, not the incoming ones.
  - Commit also occurs while stall is high. The held entry is rewritten with the same value, which is idempotent.
  - Commit also occurs on a flush edge, for the entry being displaced.
- R0:
  - Writes to R0 are discarded.
  - ReadData for address 0 is always 0, regardless of the write bus.
- Read ports:
  - Combinational, no internal bypass.
  - A read of the register being written in the same cycle returns the old value. Forwarding is the responsibility of the downstream forwarding block.
- Reset mid-operation: the pending WB entry is dropped (not committed) and the register file is cleared on the same edge.
- X-safety: with RegWrite=0, WriteData/WriteRegister contents never affect register state.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W/ADDR_W constants.
  - NUM_REGS = 2**ADDR_W.
  - ZERO_REG = 0.
  - Typedef for the MEM/WB bundle {RegWrite, WriteRegister, WriteData}, reused by the hazard/forwarding blocks.
- One sub-module, register_file: 2 read / 1 write, R0 hardwired, synchronous reset. The wrapper owns the pipeline register and the result mux.

Test Plan:
- Reset with reset=1 for 2 cycles, then read all 16 addresses -> every ReadData=0x000000, RegWrite=0.
- Load RegWrite_in=1, WriteRegister_in=5, MemToReg_in=0, ALUResult_in=0x123456:
  - cycle+1: WB bus shows R5/0x123456.
  - cycle+2: rs=5 -> ReadData1=0x123456.
  - At cycle+1, rs=5 still reads the old value 0.
- Load MemToReg_in=1, MemData_in=0xABCDEF, ALUResult_in=0x111111, dest R3 -> WriteData=0xABCDEF, then R3=0xABCDEF.
- Write 0xFFFFFF to R0 -> WB bus shows RegWrite=1/R0, but rs=0 keeps returning 0x000000.
- stall=1 for 3 cycles with R7/0x000042 latched while the inputs change -> WB bus holds R7/0x000042 and R7 = 0x000042. Simultaneous stall=1 and flush=1 -> bubble (RegWrite=0).
- Assert reset while R9/0x0000AA is on the WB bus -> on that edge R9 stays 0 and the bus clears. flush=1 on a valid incoming write to R2 -> R2 is never written.
